// File: rtl/multu_unit_pkg.sv
// rtl/multu_unit_pkg.sv - shared state encoding and HI/LO write-strobe codes for the multiplier
package multu_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } multuState_t;

    // The HI/LO block decodes these same values, so they must never be renumbered.
    localparam logic [1:0] SIG_NONE  = 2'b00;
    localparam logic [1:0] SIG_MULTU = 2'b01;
    localparam logic [1:0] SIG_MULT  = 2'b10;

    function automatic logic [1:0] doneSignal(input logic signedOp);
        return signedOp ? SIG_MULT : SIG_MULTU;
    endfunction

endpackage

// File: rtl/multu_unit_if.sv
// rtl/multu_unit_if.sv - request/result bundle between the pipeline controller and the multiplier
interface multu_unit_if #(
    parameter int WIDTH = 32
) ();

    logic                 Start;
    logic                 Signed;
    logic [WIDTH-1:0]     OpA;
    logic [WIDTH-1:0]     OpB;
    logic                 Busy;
    logic                 Done;
    logic [2*WIDTH-1:0]   MultuAns;
    logic [1:0]           Signal;

    modport master (
        output Start, Signed, OpA, OpB,
        input  Busy, Done, MultuAns, Signal
    );

    modport slave (
        input  Start, Signed, OpA, OpB,
        output Busy, Done, MultuAns, Signal
    );

endinterface

// File: rtl/multu_unit_step.sv
// rtl/multu_unit_step.sv - one combinational add-and-shift iteration of the multiplier
module multu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] accIn,
    input  logic [WIDTH-1:0]   addend,
    output logic [2*WIDTH-1:0] accOut
);

    logic [WIDTH:0] sum;

    // The carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        sum = {1'b0, accIn[2*WIDTH-1:WIDTH]};
        if (accIn[0]) begin
            sum = sum + {1'b0, addend};
        end
        accOut = {sum, accIn[WIDTH-1:1]};
    end

endmodule

// File: rtl/multu_unit.sv
// rtl/multu_unit.sv - iterative shift-add multiplier feeding HI/LO; MULT_SIGNED_EN adds signed ops
module multu_unit
    import multu_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    multu_unit_if.slave bus
);

    multuState_t          state;
    multuState_t          stateNext;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     aReg;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   accStep;
    logic [2*WIDTH-1:0]   finalAns;
    logic [WIDTH-1:0]     opAIn;
    logic [WIDTH-1:0]     opBIn;
    logic                 signedIn;
    logic                 negIn;
    logic                 signedQ;
    logic                 negQ;
    logic                 busyQ;
    logic                 doneQ;
    logic [1:0]           signalQ;
    logic [2*WIDTH-1:0]   ansQ;

`ifdef MULT_SIGNED_EN
    // Signed requests run as magnitude multiplies; the sign is reapplied on the way out.
    assign signedIn = bus.Signed;
    assign negIn    = bus.Signed & (bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1]);
    assign opAIn    = (bus.Signed && bus.OpA[WIDTH-1]) ? -bus.OpA : bus.OpA;
    assign opBIn    = (bus.Signed && bus.OpB[WIDTH-1]) ? -bus.OpB : bus.OpB;
`else
    logic unusedSigned;
    assign unusedSigned = bus.Signed;
    assign signedIn     = 1'b0;
    assign negIn        = 1'b0;
    assign opAIn        = bus.OpA;
    assign opBIn        = bus.OpB;
`endif

    assign finalAns = negQ ? -acc : acc;

    multu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .accIn  (acc),
        .addend (aReg),
        .accOut (accStep)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.Start) stateNext = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH - 1)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are registered one edge behind the state, so Done/Signal pulse as DONE retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            aReg    <= '0;
            acc     <= '0;
            signedQ <= 1'b0;
            negQ    <= 1'b0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            signalQ <= SIG_NONE;
            ansQ    <= '0;
        end else begin
            busyQ   <= (state != IDLE);
            doneQ   <= 1'b0;
            signalQ <= SIG_NONE;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        aReg    <= opAIn;
                        acc     <= {{WIDTH{1'b0}}, opBIn};
                        cnt     <= '0;
                        signedQ <= signedIn;
                        negQ    <= negIn;
                    end
                end
                RUN: begin
                    acc <= accStep;
                    cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    ansQ    <= finalAns;
                    doneQ   <= 1'b1;
                    signalQ <= doneSignal(signedQ);
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy     = busyQ;
    assign bus.Done     = doneQ;
    assign bus.Signal   = signalQ;
    assign bus.MultuAns = ansQ;

endmodule
